// File: rtl/reg_scoreboard_if.sv
// Decode <-> scoreboard bundle: issue request, variable-latency completion, squash,
// and the hazard/status results returned to decode.
interface reg_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int LATW  = 3
);
  localparam int RW = $clog2(NREGS);

  logic            req_valid;
  logic            req_use1;
  logic [RW-1:0]   req_src1;
  logic            req_use2;
  logic [RW-1:0]   req_src2;
  logic            req_wen;
  logic [RW-1:0]   req_dest;
  logic [LATW-1:0] req_lat;
  logic            cpl_valid;
  logic [RW-1:0]   cpl_dest;
  logic            squash;
  logic            stall;
  logic            issue;
  logic [RW:0]     pending_cnt;
  logic            idle;
  logic            cpl_err;

  modport master (
    output req_valid, req_use1, req_src1, req_use2, req_src2,
           req_wen, req_dest, req_lat, cpl_valid, cpl_dest, squash,
    input  stall, issue, pending_cnt, idle, cpl_err
  );

  modport slave (
    input  req_valid, req_use1, req_src1, req_use2, req_src2,
           req_wen, req_dest, req_lat, cpl_valid, cpl_dest, squash,
    output stall, issue, pending_cnt, idle, cpl_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for fixed and variable latency units;
// stall/issue are combinational, pending_cnt/idle/cpl_err are registered.
module reg_scoreboard #(
  parameter int NREGS  = 32,
  parameter int LATW   = 3,
  parameter int MAXVAR = 2,
  parameter int BYPASS = 1
) (
  input  logic            CLK,
  input  logic            RST,
  reg_scoreboard_if.slave sb
);
  localparam int RW = $clog2(NREGS);
  localparam int CW = RW + 1;

  logic [LATW-1:0]  cnt_q [NREGS];
  logic [LATW-1:0]  cnt_d [NREGS];
  logic [NREGS-1:0] var_q;
  logic [NREGS-1:0] var_d;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] rdy;
  logic [CW-1:0]    var_count;
  logic [CW-1:0]    var_post;
  logic [CW-1:0]    pend_d;
  logic [CW-1:0]    pend_q;
  logic             idle_q;
  logic             err_q;
  logic             last_vld;
  logic [RW-1:0]    last_dest;
  logic             cpl_hit;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             strct;
  logic             stall_c;
  logic             issue_c;
  logic             wr_live;

  always_comb begin
    var_count = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy[r] = (r != 0) && ((cnt_q[r] != '0) || var_q[r]);
      rdy[r]  = (r == 0) || !busy[r] ||
                ((BYPASS != 0) &&
                 (((cnt_q[r] == LATW'(1)) && !var_q[r]) ||
                  (var_q[r] && sb.cpl_valid && (sb.cpl_dest == RW'(r)))));
      var_count = var_count + CW'(var_q[r]);
    end
  end

  // A completion landing this cycle frees its variable slot for a same-cycle issue.
  assign cpl_hit  = sb.cpl_valid & var_q[sb.cpl_dest];
  assign var_post = var_count - CW'(cpl_hit);

  assign raw1  = sb.req_use1 & ~rdy[sb.req_src1];
  assign raw2  = sb.req_use2 & ~rdy[sb.req_src2];
  assign waw   = sb.req_wen & (sb.req_dest != '0) & busy[sb.req_dest];
  assign strct = sb.req_wen & (sb.req_lat == '0) & (var_post >= CW'(MAXVAR));

  assign stall_c = sb.req_valid & (raw1 | raw2 | waw | strct);
  assign issue_c = sb.req_valid & ~stall_c & ~sb.squash;
  assign wr_live = issue_c & sb.req_wen & (sb.req_dest != '0);

  always_comb begin
    pend_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LATW'(1)) : '0;
      var_d[r] = var_q[r] & ~(sb.cpl_valid && (sb.cpl_dest == RW'(r)));
      if (wr_live && (sb.req_dest == RW'(r))) begin
        if (sb.req_lat != '0) begin
          cnt_d[r] = sb.req_lat;
        end else begin
          var_d[r] = 1'b1;
        end
      end
      // The squashed write found its dest idle (WAW), so clearing fully undoes it.
      if (sb.squash && last_vld && (last_dest == RW'(r))) begin
        cnt_d[r] = '0;
        var_d[r] = 1'b0;
      end
      if (r == 0) begin
        cnt_d[r] = '0;
        var_d[r] = 1'b0;
      end
      busy_d[r] = (cnt_d[r] != '0) || var_d[r];
      pend_d    = pend_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      var_q     <= '0;
      pend_q    <= '0;
      idle_q    <= 1'b1;
      err_q     <= 1'b0;
      last_vld  <= 1'b0;
      last_dest <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      var_q     <= var_d;
      pend_q    <= pend_d;
      idle_q    <= (pend_d == '0);
      err_q     <= err_q | (sb.cpl_valid & ~var_q[sb.cpl_dest]);
      last_vld  <= wr_live;
      last_dest <= sb.req_dest;
    end
  end

  assign sb.stall       = stall_c;
  assign sb.issue       = issue_c;
  assign sb.pending_cnt = pend_q;
  assign sb.idle        = idle_q;
  assign sb.cpl_err     = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a time-stamp based reference model.
module tb_reg_scoreboard;
  localparam int NREGS  = 32;
  localparam int LATW   = 3;
  localparam int MAXVAR = 2;
  localparam int RW     = $clog2(NREGS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREGS(NREGS), .LATW(LATW)) sbif ();

  reg_scoreboard #(.NREGS(NREGS), .LATW(LATW), .MAXVAR(MAXVAR), .BYPASS(1)) dut (
    .CLK (clk),
    .RST (rst),
    .sb  (sbif.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: fixed-latency write is busy while cyc < done_at; variable write while mvar.
  int cyc = 0;
  int done_at [NREGS];
  bit mvar    [NREGS];
  bit merr;
  bit lvld;
  int ldest;
  int mpend;
  bit midle;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int r);
    return (r != 0) && ((cyc < done_at[r]) || mvar[r]);
  endfunction

  function automatic bit m_ready(input int s, input bit cv, input int cd);
    if (s == 0 || !m_busy(s)) return 1'b1;
    if (!mvar[s] && (cyc == done_at[s] - 1)) return 1'b1;
    return mvar[s] && cv && (cd == s);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      done_at[r] = 0;
      mvar[r]    = 1'b0;
    end
    merr  = 1'b0;
    lvld  = 1'b0;
    ldest = 0;
    mpend = 0;
    midle = 1'b1;
  endtask

  task automatic model_step();
    bit cv, e_stall, e_issue, v, u1, u2, w, sq;
    int cd, s1, s2, d, lat, vc, post;
    v   = sbif.req_valid;  u1 = sbif.req_use1;  u2 = sbif.req_use2;
    w   = sbif.req_wen;    sq = sbif.squash;    cv = sbif.cpl_valid;
    s1  = int'(sbif.req_src1);  s2 = int'(sbif.req_src2);
    d   = int'(sbif.req_dest);  lat = int'(sbif.req_lat);
    cd  = int'(sbif.cpl_dest);
    vc  = 0;
    for (int r = 0; r < NREGS; r++) vc += int'(mvar[r]);
    post = vc - ((cv && mvar[cd]) ? 1 : 0);
    e_stall = v && ((u1 && !m_ready(s1, cv, cd)) || (u2 && !m_ready(s2, cv, cd)) ||
                    (w && d != 0 && m_busy(d)) || (w && lat == 0 && post >= MAXVAR));
    e_issue = v && !e_stall && !sq;
    check("pending_cnt", 32'(sbif.pending_cnt), mpend);
    check("idle", 32'(sbif.idle), 32'(midle));
    check("cpl_err", 32'(sbif.cpl_err), 32'(merr));
    check("stall", 32'(sbif.stall), 32'(e_stall));
    check("issue", 32'(sbif.issue), 32'(e_issue));
    if (cv) begin
      if (mvar[cd]) mvar[cd] = 1'b0;
      else merr = 1'b1;
    end
    if (sq && lvld) begin
      done_at[ldest] = 0;
      mvar[ldest]    = 1'b0;
    end
    if (e_issue && w && d != 0) begin
      if (lat != 0) done_at[d] = cyc + 1 + lat;
      else mvar[d] = 1'b1;
    end
    lvld  = e_issue && w && d != 0;
    ldest = d;
    cyc++;
    mpend = 0;
    for (int r = 0; r < NREGS; r++) mpend += int'(m_busy(r));
    midle = (mpend == 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        check("rst_pending", 32'(sbif.pending_cnt), 0);
        check("rst_idle", 32'(sbif.idle), 1);
        check("rst_err", 32'(sbif.cpl_err), 0);
      end else begin
        model_step();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    sbif.req_valid = 1'b0; sbif.req_use1 = 1'b0; sbif.req_src1 = '0;
    sbif.req_use2  = 1'b0; sbif.req_src2 = '0;   sbif.req_wen  = 1'b0;
    sbif.req_dest  = '0;   sbif.req_lat  = '0;   sbif.cpl_valid = 1'b0;
    sbif.cpl_dest  = '0;   sbif.squash   = 1'b0;
  endtask

  task automatic req(input bit u1, input int s1, input bit u2, input int s2,
                     input bit w, input int d, input int l);
    sbif.req_valid = 1'b1;
    sbif.req_use1 = u1; sbif.req_src1 = RW'(s1);
    sbif.req_use2 = u2; sbif.req_src2 = RW'(s2);
    sbif.req_wen  = w;  sbif.req_dest = RW'(d);
    sbif.req_lat  = LATW'(l);
  endtask

  task automatic cpl(input bit v, input int d);
    sbif.cpl_valid = v;
    sbif.cpl_dest  = RW'(d);
  endtask

  task automatic directed();
    // load-use with bypass
    req(0, 0, 0, 0, 1, 5, 2);   @(negedge clk); check("lu_issue0", 32'(sbif.issue), 1); tick();
    req(1, 5, 0, 0, 0, 0, 0);   @(negedge clk); check("lu_stall", 32'(sbif.stall), 1);  tick();
    @(negedge clk); check("lu_issue_byp", 32'(sbif.issue), 1); tick();
    drive_idle(); tick(); tick();
    // WAW against a variable-latency write
    req(0, 0, 0, 0, 1, 7, 0);   @(negedge clk); check("waw_issue0", 32'(sbif.issue), 1); tick();
    req(0, 0, 0, 0, 1, 7, 1);   @(negedge clk); check("waw_stall1", 32'(sbif.stall), 1); tick();
    @(negedge clk); check("waw_stall2", 32'(sbif.stall), 1); tick();
    cpl(1, 7);                  @(negedge clk); check("waw_stall_cpl", 32'(sbif.stall), 1); tick();
    cpl(0, 0);                  @(negedge clk); check("waw_issue", 32'(sbif.issue), 1); tick();
    drive_idle(); tick(); tick();
    // structural limit on variable-latency writes
    req(0, 0, 0, 0, 1, 3, 0);   @(negedge clk); check("st_issue3", 32'(sbif.issue), 1); tick();
    req(0, 0, 0, 0, 1, 4, 0);   @(negedge clk); check("st_issue4", 32'(sbif.issue), 1); tick();
    req(0, 0, 0, 0, 1, 6, 0);   @(negedge clk); check("st_stall", 32'(sbif.stall), 1); tick();
    cpl(1, 3);                  @(negedge clk); check("st_issue_cpl", 32'(sbif.issue), 1); tick();
    drive_idle();               @(negedge clk); check("st_pend2", 32'(sbif.pending_cnt), 2); tick();
    cpl(1, 4); tick(); cpl(1, 6); tick(); cpl(0, 0); tick();
    // squash of the previous issue
    req(0, 0, 0, 0, 1, 9, 3);   @(negedge clk); check("sq_issue0", 32'(sbif.issue), 1); tick();
    req(1, 9, 0, 0, 0, 0, 0); sbif.squash = 1'b1;
    @(negedge clk); check("sq_issue_killed", 32'(sbif.issue), 0); tick();
    sbif.squash = 1'b0;
    @(negedge clk); check("sq_ready", 32'(sbif.issue), 1);
    check("sq_pend0", 32'(sbif.pending_cnt), 0); tick();
    drive_idle(); tick();
    // stray completion and writes to r0
    cpl(1, 12); tick(); cpl(0, 0);
    @(negedge clk); check("err_set", 32'(sbif.cpl_err), 1); tick(); tick();
    @(negedge clk); check("err_sticky", 32'(sbif.cpl_err), 1); tick();
    req(0, 0, 0, 0, 1, 0, 5);   @(negedge clk); check("r0_issue", 32'(sbif.issue), 1); tick();
    drive_idle();               @(negedge clk); check("r0_pend0", 32'(sbif.pending_cnt), 0); tick();
    // asynchronous reset with three busy registers
    req(0, 0, 0, 0, 1, 10, 0); tick();
    req(0, 0, 0, 0, 1, 11, 0); tick();
    req(0, 0, 0, 0, 1, 13, 7); tick();
    drive_idle();               @(negedge clk); check("rs_pend3", 32'(sbif.pending_cnt), 3); tick();
    rst = 1'b1;
    @(negedge clk);
    check("rs_pend0", 32'(sbif.pending_cnt), 0);
    check("rs_idle", 32'(sbif.idle), 1);
    check("rs_err0", 32'(sbif.cpl_err), 0);
    tick(); rst = 1'b0;
    req(1, 10, 1, 11, 1, 13, 0); @(negedge clk); check("rs_issue", 32'(sbif.issue), 1); tick();
    drive_idle(); cpl(1, 13); tick(); cpl(0, 0); tick();
  endtask

  task automatic random_phase(input int n);
    int r, pick;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        drive_idle(); rst = 1'b1; tick(); rst = 1'b0;
      end
      sbif.req_valid = ($urandom_range(0, 3) != 0);
      sbif.req_use1  = $urandom_range(0, 1) != 0;
      sbif.req_src1  = RW'($urandom_range(0, 7));
      sbif.req_use2  = $urandom_range(0, 1) != 0;
      sbif.req_src2  = RW'($urandom_range(0, 7));
      sbif.req_wen   = $urandom_range(0, 3) != 0;
      sbif.req_dest  = RW'($urandom_range(0, 7));
      sbif.req_lat   = ($urandom_range(0, 2) == 0) ? '0 : LATW'($urandom_range(1, 7));
      sbif.squash    = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 49);
      cpl(0, 0);
      if (r < 20) begin
        pick = $urandom_range(1, 7);
        for (int k = 0; k < 8; k++) begin
          if (mvar[(pick + k) % 8] && !sbif.cpl_valid) cpl(1, (pick + k) % 8);
        end
      end else if (r == 49) begin
        cpl(1, $urandom_range(0, 15));
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    tick(); tick();
    rst = 1'b0;
    tick();
    directed();
    random_phase(3000);
    drive_idle();
    tick();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
